// File: rtl/uart_tx_rr_sched_pkg.sv
// rtl/uart_tx_rr_sched_pkg.sv - shared state encoding and defaults for the uart tx scheduler
package uart_tx_rr_sched_pkg;
  localparam int DEFAULT_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } state_t;
endpackage

// File: rtl/uart_tx_rr_sched_if.sv
// rtl/uart_tx_rr_sched_if.sv - requester and uart_tx side signals of the scheduler
interface uart_tx_rr_sched_if
  import uart_tx_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN   = DEFAULT_LEN
);
  logic [N_REQ-1:0]     req;
  logic [N_REQ*LEN-1:0] req_data;
  logic [N_REQ-1:0]     grant_ack;
  logic [N_REQ-1:0]     done;
  logic                 busy;
  logic                 uart_en;
  logic [LEN-1:0]       uart_data;
  logic                 uart_done_tick;
  logic                 timeout_err;

  modport master (
    output req, req_data, uart_done_tick,
    input  grant_ack, done, busy, uart_en, uart_data, timeout_err
  );

  modport slave (
    input  req, req_data, uart_done_tick,
    output grant_ack, done, busy, uart_en, uart_data, timeout_err
  );
endinterface

// File: rtl/uart_tx_rr_sched_rr_pick.sv
// rtl/uart_tx_rr_sched_rr_pick.sv - combinational rotate-priority picker
// The search starts just after rr_ptr, so the last winner has lowest priority.
module uart_tx_rr_sched_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        index       = cand;
        grant[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_rr_sched.sv
// rtl/uart_tx_rr_sched.sv - round-robin sharing of one uart_tx among N_REQ byte producers
// One byte in flight; a watchdog recovers when the serializer never reports done.
module uart_tx_rr_sched
  import uart_tx_rr_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LEN       = DEFAULT_LEN,
  parameter int TIMEOUT_W = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_rr_sched_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  state_t               state, state_next;
  logic [IDX_W-1:0]     rr_ptr, owner, pick_index;
  logic [N_REQ-1:0]     pick_grant;
  logic                 pick_valid;
  logic [TIMEOUT_W-1:0] watchdog;
  logic [LEN-1:0]       sel_data, data_q;
  logic [N_REQ-1:0]     grant_ack_q, done_q, grant_ack_next, done_next;
  logic                 uart_en_q, timeout_q, en_next, timeout_next, accept;

  uart_tx_rr_sched_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_index == IDX_W'(i)) sel_data = bus.req_data[i*LEN +: LEN];
    end
  end

  always_comb begin
    state_next     = state;
    grant_ack_next = '0;
    done_next      = '0;
    en_next        = 1'b0;
    timeout_next   = 1'b0;
    accept         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          accept         = 1'b1;
          grant_ack_next = pick_grant;
          en_next        = 1'b1;
          state_next     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A done tick landing on the expiry cycle still counts as a good transfer.
        if (bus.uart_done_tick) begin
          done_next[owner] = 1'b1;
          state_next       = ST_GAP;
        end else if (watchdog == WD_MAX) begin
          timeout_next = 1'b1;
          state_next   = ST_GAP;
        end
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_ack_q <= '0;
      done_q      <= '0;
      uart_en_q   <= 1'b0;
      timeout_q   <= 1'b0;
      data_q      <= '0;
      owner       <= '0;
      rr_ptr      <= IDX_W'(N_REQ - 1);
      watchdog    <= '0;
    end else begin
      grant_ack_q <= grant_ack_next;
      done_q      <= done_next;
      uart_en_q   <= en_next;
      timeout_q   <= timeout_next;
      if (accept) begin
        data_q   <= sel_data;
        owner    <= pick_index;
        rr_ptr   <= pick_index;
        watchdog <= '0;
      end else if (state == ST_WAIT_DONE && watchdog != WD_MAX) begin
        watchdog <= watchdog + 1'b1;
      end
    end
  end

  assign bus.grant_ack   = grant_ack_q;
  assign bus.done        = done_q;
  assign bus.uart_en     = uart_en_q;
  assign bus.uart_data   = data_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state != ST_IDLE);
endmodule
